// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the pipeline hazard logic.
package pipe_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC8 = 2'b10;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // $0 is hardwired to zero, so a zero destination never produces a hazard.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Stage-information bundle between the pipeline datapath and the hazard controller.
interface hazard_ctrl_if;
  import pipe_pkg::*;

  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] MemtoRegE, MemtoRegM;
  logic       BranchD, JrD, MdUseD, MdStartE, MdDivE;
  logic       StallF, StallD, FlushE;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MdBusy;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JrD, MdUseD, MdStartE, MdDivE,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JrD, MdUseD, MdStartE, MdDivE,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy
  );

endinterface

// File: rtl/md_busy_counter.sv
// HI/LO busy counter: loads the operation latency on issue and counts down to idle.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic MdStartE,
  input  logic MdDivE,
  output logic MdBusy
);

  localparam int CNT_W = $clog2(DIV_CYC + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [CNT_W-1:0] count_d, count_q;
  logic [0:0]       state;

  assign state = (count_q != '0) ? ST_BUSY : ST_IDLE;

  // A start while busy is illegal (mdstall blocks it), so it is simply ignored.
  always_comb begin
    count_d = count_q;
    case (state)
      ST_IDLE: begin
        if (MdStartE) begin
          count_d = MdDivE ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end
      end
      default: count_d = count_q - CNT_W'(1);
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign MdBusy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, stalls and HI/LO interlock.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input logic          Clk,
  input logic          Reset,
  hazard_ctrl_if.slave bus
);

  logic md_busy;
  logic lw_stall, branch_stall, jr_stall, md_stall, stall;
  logic e_hits_rs, e_hits_rt, m_load_hits_rs, m_load_hits_rt;
  fwd_sel_e fwd_ae, fwd_be;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy (
    .Clk      (Clk),
    .Reset    (Reset),
    .MdStartE (bus.MdStartE),
    .MdDivE   (bus.MdDivE),
    .MdBusy   (md_busy)
  );

  // A branch/jr resolved in D needs its operands now: any pending write in E,
  // or a load still in M, cannot be forwarded in time.
  always_comb begin
    e_hits_rs      = bus.RegWriteE && reg_match(bus.WriteRegE, bus.RsD);
    e_hits_rt      = bus.RegWriteE && reg_match(bus.WriteRegE, bus.RtD);
    m_load_hits_rs = (bus.MemtoRegM == MTR_MEM) && reg_match(bus.WriteRegM, bus.RsD);
    m_load_hits_rt = (bus.MemtoRegM == MTR_MEM) && reg_match(bus.WriteRegM, bus.RtD);

    lw_stall     = (bus.MemtoRegE == MTR_MEM) &&
                   (reg_match(bus.WriteRegE, bus.RsD) || reg_match(bus.WriteRegE, bus.RtD));
    branch_stall = bus.BranchD &&
                   (e_hits_rs || e_hits_rt || m_load_hits_rs || m_load_hits_rt);
    jr_stall     = bus.JrD && (e_hits_rs || m_load_hits_rs);
    md_stall     = bus.MdUseD && (md_busy || bus.MdStartE);
    stall        = lw_stall || branch_stall || jr_stall || md_stall;
  end

  always_comb begin
    fwd_ae = FWD_RF;
    if (bus.RegWriteM && reg_match(bus.WriteRegM, bus.RsE)) begin
      fwd_ae = FWD_M;
    end else if (bus.RegWriteW && reg_match(bus.WriteRegW, bus.RsE)) begin
      fwd_ae = FWD_W;
    end

    fwd_be = FWD_RF;
    if (bus.RegWriteM && reg_match(bus.WriteRegM, bus.RtE)) begin
      fwd_be = FWD_M;
    end else if (bus.RegWriteW && reg_match(bus.WriteRegW, bus.RtE)) begin
      fwd_be = FWD_W;
    end
  end

  // Reset quiets every control output so the pipeline registers see no stale requests.
  always_comb begin
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.ForwardAD = 1'b0;
    bus.ForwardBD = 1'b0;
    bus.ForwardAE = FWD_RF;
    bus.ForwardBE = FWD_RF;
    if (!Reset) begin
      bus.StallF    = stall;
      bus.StallD    = stall;
      bus.FlushE    = stall;
      bus.ForwardAD = bus.RegWriteM && reg_match(bus.WriteRegM, bus.RsD);
      bus.ForwardBD = bus.RegWriteM && reg_match(bus.WriteRegM, bus.RtD);
      bus.ForwardAE = fwd_ae;
      bus.ForwardBE = fwd_be;
    end
  end

  assign bus.MdBusy = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors queue expectations, a monitor checks them.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (hif)
  );

  typedef struct packed {
    logic       stall;
    logic       fad;
    logic       fbd;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic clear_inputs();
    Reset         = 1'b0;
    hif.RsD       = '0;
    hif.RtD       = '0;
    hif.RsE       = '0;
    hif.RtE       = '0;
    hif.WriteRegE = '0;
    hif.WriteRegM = '0;
    hif.WriteRegW = '0;
    hif.RegWriteE = 1'b0;
    hif.RegWriteM = 1'b0;
    hif.RegWriteW = 1'b0;
    hif.MemtoRegE = MTR_ALU;
    hif.MemtoRegM = MTR_ALU;
    hif.BranchD   = 1'b0;
    hif.JrD       = 1'b0;
    hif.MdUseD    = 1'b0;
    hif.MdStartE  = 1'b0;
    hif.MdDivE    = 1'b0;
  endtask

  // Inputs for this cycle are already driven; queue what the DUT must show, then advance.
  task automatic apply_stimulus(input string nm, input logic stall, input logic fad,
                                input logic fbd, input logic [1:0] fae,
                                input logic [1:0] fbe, input logic busy);
    exp_t e;
    e.stall = stall;
    e.fad   = fad;
    e.fbd   = fbd;
    e.fae   = fae;
    e.fbe   = fbe;
    e.busy  = busy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_output(input string nm, input exp_t e);
    logic [8:0] act, req;
    act = {hif.StallF, hif.StallD, hif.FlushE, hif.ForwardAD, hif.ForwardBD,
           hif.ForwardAE, hif.ForwardBE, hif.MdBusy};
    req = {e.stall, e.stall, e.stall, e.fad, e.fbd, e.fae, e.fbe, e.busy};
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got StallF/D/FlushE=%b%b%b FAD=%b FBD=%b FAE=%b FBE=%b Busy=%b, want stall=%b FAD=%b FBD=%b FAE=%b FBE=%b Busy=%b",
               nm, hif.StallF, hif.StallD, hif.FlushE, hif.ForwardAD, hif.ForwardBD,
               hif.ForwardAE, hif.ForwardBE, hif.MdBusy,
               e.stall, e.fad, e.fbd, e.fae, e.fbe, e.busy);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_output(nm, e);
      end
    end
  end

  initial begin : driver
    clear_inputs();
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Reset held with hazards present: everything forced quiet, counter cleared.
    clear_inputs();
    Reset = 1'b1;
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd5; hif.RsE = 5'd5; hif.RsD = 5'd5;
    hif.MemtoRegE = MTR_MEM; hif.WriteRegE = 5'd5;
    apply_stimulus("reset_quiet", 0, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    apply_stimulus("idle", 0, 0, 0, 2'b00, 2'b00, 0);

    // Load-use: lw $8 in E, add $9,$8,$10 in D.
    clear_inputs();
    hif.MemtoRegE = MTR_MEM; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd8;
    hif.RsD = 5'd8; hif.RtD = 5'd10;
    apply_stimulus("lw_use_stall", 1, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.MemtoRegM = MTR_MEM; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd8;
    hif.RsD = 5'd8; hif.RtD = 5'd10;
    apply_stimulus("lw_in_m_no_stall", 0, 1, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd8; hif.RsE = 5'd8; hif.RtE = 5'd10;
    apply_stimulus("lw_w_fwd_ae", 0, 0, 0, 2'b01, 2'b00, 0);

    clear_inputs();
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd5;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd5; hif.RsE = 5'd5; hif.RtE = 5'd5;
    apply_stimulus("m_priority", 0, 0, 0, 2'b10, 2'b10, 0);

    clear_inputs();
    hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1; hif.RegWriteE = 1'b1;
    hif.BranchD = 1'b1;
    apply_stimulus("reg0_never", 0, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd3; hif.RsE = 5'd3;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd7; hif.RtE = 5'd7;
    apply_stimulus("split_m_w", 0, 0, 0, 2'b10, 2'b01, 0);

    clear_inputs();
    hif.RegWriteM = 1'b0; hif.WriteRegM = 5'd6; hif.RsE = 5'd6;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd6;
    apply_stimulus("m_disabled", 0, 0, 0, 2'b01, 2'b00, 0);

    // beq $3,$4 with producer of $4 in E, then in M.
    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd3; hif.RtD = 5'd4;
    hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd4;
    apply_stimulus("beq_e_stall", 1, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd3; hif.RtD = 5'd4;
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd4; hif.MemtoRegM = MTR_ALU;
    apply_stimulus("beq_m_fwd_bd", 0, 0, 1, 2'b00, 2'b00, 0);

    // Load feeding a branch: two stall cycles, then resolved.
    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd9; hif.RtD = 5'd2;
    hif.MemtoRegE = MTR_MEM; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd9;
    apply_stimulus("lw_br_stall1", 1, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd9; hif.RtD = 5'd2;
    hif.MemtoRegM = MTR_MEM; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd9;
    apply_stimulus("lw_br_stall2", 1, 1, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd9; hif.RtD = 5'd2;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd9;
    apply_stimulus("lw_br_done", 0, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.MemtoRegE = MTR_PC8; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd8; hif.RsD = 5'd8;
    apply_stimulus("pc8_no_lwstall", 0, 0, 0, 2'b00, 2'b00, 0);

    // jr $31: only rs is compared.
    clear_inputs();
    hif.JrD = 1'b1; hif.RsD = 5'd31; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd31;
    apply_stimulus("jr_e_stall", 1, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.JrD = 1'b1; hif.RsD = 5'd2; hif.RtD = 5'd31;
    hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd31;
    apply_stimulus("jr_rt_ignored", 0, 0, 0, 2'b00, 2'b00, 0);

    clear_inputs();
    hif.JrD = 1'b1; hif.RsD = 5'd31;
    hif.MemtoRegM = MTR_MEM; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd31;
    apply_stimulus("jr_m_load_stall", 1, 1, 0, 2'b00, 2'b00, 0);

    // div issued at cycle 0 with mflo waiting in D.
    clear_inputs();
    hif.MdStartE = 1'b1; hif.MdDivE = 1'b1; hif.MdUseD = 1'b1;
    apply_stimulus("div_c0", 1, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 1; i <= 10; i++) begin
      clear_inputs();
      hif.MdUseD = 1'b1;
      apply_stimulus($sformatf("div_c%0d", i), 1, 0, 0, 2'b00, 2'b00, 1);
    end
    clear_inputs();
    hif.MdUseD = 1'b1;
    apply_stimulus("div_c11", 0, 0, 0, 2'b00, 2'b00, 0);

    // mult, then a stray start mid-flight which must not reload the count.
    clear_inputs();
    hif.MdStartE = 1'b1;
    apply_stimulus("mult_c0", 0, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 1; i <= 5; i++) begin
      clear_inputs();
      hif.MdUseD = 1'b1;
      if (i == 3) begin
        hif.MdStartE = 1'b1; hif.MdDivE = 1'b1;
      end
      apply_stimulus($sformatf("mult_c%0d", i), 1, 0, 0, 2'b00, 2'b00, 1);
    end
    clear_inputs();
    hif.MdUseD = 1'b1;
    apply_stimulus("mult_c6", 0, 0, 0, 2'b00, 2'b00, 0);

    // mult abandoned by reset in cycle 2.
    clear_inputs();
    hif.MdStartE = 1'b1;
    apply_stimulus("mrst_c0", 0, 0, 0, 2'b00, 2'b00, 0);
    clear_inputs();
    apply_stimulus("mrst_c1", 0, 0, 0, 2'b00, 2'b00, 1);
    clear_inputs();
    Reset = 1'b1;
    hif.MdUseD = 1'b1; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd4;
    hif.RsE = 5'd4; hif.RtD = 5'd4;
    apply_stimulus("mrst_c2", 0, 0, 0, 2'b00, 2'b00, 1);
    clear_inputs();
    hif.MdUseD = 1'b1;
    apply_stimulus("mrst_c3", 0, 0, 0, 2'b00, 2'b00, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge Clk);
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
